// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank_tri register bank: operation encodings.
package reg_bank_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

endpackage : reg_bank_pkg

// File: rtl/reg_cell.sv
// One register of the bank. It performs LOAD/INC/SHL/SHR when selected and
// offers the carry/shift-out bit of that operation as a candidate for cy.
module reg_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;
    logic             cout_s;

    // Next register value and carry-out for the requested operation.
    always_comb begin
        next_s = q_r;
        cout_s = 1'b0;
        case (op)
            OP_LOAD: begin
                next_s = wdata;
                cout_s = 1'b0;
            end
            OP_INC: begin
                // Sum at WIDTH+1 bits so wrap-around from all-ones lands in the carry.
                {cout_s, next_s} = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
            end
            OP_SHL: begin
                cout_s = q_r[WIDTH-1];
                next_s = {q_r[WIDTH-2:0], sin};
            end
            OP_SHR: begin
                cout_s = q_r[0];
                next_s = {sin, q_r[WIDTH-1:1]};
            end
            default: begin
                next_s = q_r;
                cout_s = 1'b0;
            end
        endcase
    end

    // Register storage: clear wins over a pending operation.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r <= {WIDTH{1'b0}};
        end else if (sel) begin
            q_r <= next_s;
        end else begin
            q_r <= q_r;
        end
    end

    assign q    = q_r;
    assign cout = cout_s;

endmodule : reg_cell

// File: rtl/reg_bank_tri.sv
// DEPTH x WIDTH register bank with one operate port, a tri-state bus read
// port (active-low enable), an always-driven read port, a carry/shift-out
// flag and a per-register written mask.
module reg_bank_tri
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [1:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sin,
    input  logic [AW-1:0]    ra,
    input  logic             oe_,
    output logic [WIDTH-1:0] bus,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] qb,
    output logic             cy,
    output logic [DEPTH-1:0] wmask
);

    logic [WIDTH-1:0] q_arr_s [DEPTH];
    logic [DEPTH-1:0] cout_arr_s;
    logic [WIDTH-1:0] rd_a_s;
    logic [WIDTH-1:0] rd_b_s;
    logic             cy_r;
    logic [DEPTH-1:0] wmask_r;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            reg_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk   (clk),
                .clr   (clr),
                .sel   (we && (waddr == AW'(gi))),
                .op    (op),
                .wdata (wdata),
                .sin   (sin),
                .q     (q_arr_s[gi]),
                .cout  (cout_arr_s[gi])
            );
        end
    endgenerate

    // Carry flag: takes the selected cell's carry on INC/SHL/SHR, holds on LOAD or idle.
    always_ff @(posedge clk) begin
        if (clr) begin
            cy_r <= 1'b0;
        end else if (we && (op != OP_LOAD)) begin
            cy_r <= cout_arr_s[waddr];
        end else begin
            cy_r <= cy_r;
        end
    end

    // Written mask: sticky per-register flag, set by any operation on that register.
    always_ff @(posedge clk) begin
        if (clr) begin
            wmask_r <= {DEPTH{1'b0}};
        end else if (we) begin
            wmask_r <= wmask_r | ({{(DEPTH-1){1'b0}}, 1'b1} << waddr);
        end else begin
            wmask_r <= wmask_r;
        end
    end

    // Zero-latency read muxes straight from the array, so a same-cycle write shows the old value.
    always_comb begin
        rd_a_s = q_arr_s[ra];
        rd_b_s = q_arr_s[rb];
    end

    // The enable only gates the bus driver; storage is unaffected by oe_.
    assign bus   = oe_ ? {WIDTH{1'bz}} : rd_a_s;
    assign qb    = rd_b_s;
    assign cy    = cy_r;
    assign wmask = wmask_r;

endmodule : reg_bank_tri

// File: tb/tb_reg_bank_tri.sv
// Directed self-checking bench for reg_bank_tri (WIDTH=8, DEPTH=4).
module tb_reg_bank_tri;
    import reg_bank_pkg::*;

    logic       clk = 1'b0;
    logic       clr;
    logic       we;
    logic [1:0] op;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       sin;
    logic [1:0] ra;
    logic       oe_;
    wire  [7:0] bus;
    logic [1:0] rb;
    logic [7:0] qb;
    logic       cy;
    logic [3:0] wmask;

    int vectors     = 0;
    int miscompares = 0;

    // Weak-side keeper: puts a known pattern on the bus whenever the DUT
    // should have released it, so a released bus reads back as KEEP.
    localparam logic [7:0] KEEP = 8'h5A;
    assign bus = oe_ ? KEEP : 8'hzz;

    always #5 clk = ~clk;

    reg_bank_tri dut (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .op    (op),
        .waddr (waddr),
        .wdata (wdata),
        .sin   (sin),
        .ra    (ra),
        .oe_   (oe_),
        .bus   (bus),
        .rb    (rb),
        .qb    (qb),
        .cy    (cy),
        .wmask (wmask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] a, input logic [1:0] o,
                         input logic [7:0] d, input logic s);
        we = 1'b1; waddr = a; op = o; wdata = d; sin = s;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        do_op(2'd0, OP_LOAD, 8'hFF, 1'b0);
        do_op(2'd0, OP_INC,  8'h00, 1'b0);   // R0 wraps, cy=1
        do_op(2'd3, OP_LOAD, 8'hC3, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rb = i[1:0];
            #1;
            vectors++;
            if (qb !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h expected 00", i, qb);
            end
        end
        vectors++;
        if (cy !== 1'b0) begin miscompares++; $display("FAIL reset_cy: got %b expected 0", cy); end
        vectors++;
        if (wmask !== 4'b0000) begin miscompares++; $display("FAIL reset_wmask: got %b expected 0000", wmask); end
        ra = 2'd3; oe_ = 1'b0; #1;
        vectors++;
        if (bus !== 8'h00) begin miscompares++; $display("FAIL reset_bus_on: got %h expected 00", bus); end
        oe_ = 1'b1; #1;
        vectors++;
        if (bus !== KEEP) begin miscompares++; $display("FAIL reset_bus_z: got %h expected released (%h)", bus, KEEP); end
    endtask

    task automatic test_load_readback();
        oe_ = 1'b0; ra = 2'd2; rb = 2'd1;
        we = 1'b1; op = OP_LOAD; waddr = 2'd2; wdata = 8'hA5;
        #1;
        vectors++;
        if (bus !== 8'h00) begin miscompares++; $display("FAIL load_old_bus: got %h expected 00", bus); end
        tick();
        waddr = 2'd1; wdata = 8'h3C;
        #1;
        vectors++;
        if (qb !== 8'h00) begin miscompares++; $display("FAIL load_old_qb: got %h expected 00", qb); end
        vectors++;
        if (bus !== 8'hA5) begin miscompares++; $display("FAIL load_new_bus_early: got %h expected a5", bus); end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (bus !== 8'hA5) begin miscompares++; $display("FAIL load_bus: got %h expected a5", bus); end
        vectors++;
        if (qb !== 8'h3C) begin miscompares++; $display("FAIL load_qb: got %h expected 3c", qb); end
        vectors++;
        if (wmask !== 4'b0110) begin miscompares++; $display("FAIL load_wmask: got %b expected 0110", wmask); end
    endtask

    task automatic test_inc_wrap();
        rb = 2'd0;
        do_op(2'd0, OP_LOAD, 8'hFE, 1'b0);
        do_op(2'd0, OP_INC,  8'h00, 1'b0);
        vectors++;
        if (qb !== 8'hFF || cy !== 1'b0) begin
            miscompares++; $display("FAIL inc1: got R0=%h cy=%b expected ff/0", qb, cy);
        end
        do_op(2'd0, OP_INC, 8'h00, 1'b0);
        vectors++;
        if (qb !== 8'h00 || cy !== 1'b1) begin
            miscompares++; $display("FAIL inc_wrap: got R0=%h cy=%b expected 00/1", qb, cy);
        end
        do_op(2'd1, OP_LOAD, 8'h12, 1'b0);
        vectors++;
        if (cy !== 1'b1) begin miscompares++; $display("FAIL load_keeps_cy: got %b expected 1", cy); end
        vectors++;
        if (qb !== 8'h00) begin miscompares++; $display("FAIL inc_r0_hold: got %h expected 00", qb); end
        rb = 2'd1; #1;
        vectors++;
        if (qb !== 8'h12) begin miscompares++; $display("FAIL inc_r1_load: got %h expected 12", qb); end
        vectors++;
        if (wmask !== 4'b0111) begin miscompares++; $display("FAIL inc_wmask: got %b expected 0111", wmask); end
    endtask

    task automatic test_shift();
        rb = 2'd3;
        do_op(2'd3, OP_LOAD, 8'b1000_0001, 1'b0);
        vectors++;
        if (qb !== 8'b1000_0001 || cy !== 1'b1) begin
            miscompares++; $display("FAIL shift_load: got R3=%b cy=%b expected 10000001/1", qb, cy);
        end
        do_op(2'd3, OP_SHL, 8'h00, 1'b0);
        vectors++;
        if (qb !== 8'b0000_0010 || cy !== 1'b1) begin
            miscompares++; $display("FAIL shl: got R3=%b cy=%b expected 00000010/1", qb, cy);
        end
        do_op(2'd3, OP_SHR, 8'h00, 1'b1);
        vectors++;
        if (qb !== 8'b1000_0001 || cy !== 1'b0) begin
            miscompares++; $display("FAIL shr_sin1: got R3=%b cy=%b expected 10000001/0", qb, cy);
        end
        do_op(2'd3, OP_SHR, 8'h00, 1'b0);
        vectors++;
        if (qb !== 8'b0100_0000 || cy !== 1'b1) begin
            miscompares++; $display("FAIL shr_sin0: got R3=%b cy=%b expected 01000000/1", qb, cy);
        end
        vectors++;
        if (wmask !== 4'b1111) begin miscompares++; $display("FAIL shift_wmask: got %b expected 1111", wmask); end
    endtask

    task automatic test_simultaneous();
        clr = 1'b1; we = 1'b1; op = OP_LOAD; waddr = 2'd0; wdata = 8'h55;
        tick();
        clr = 1'b0; we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rb = i[1:0];
            #1;
            vectors++;
            if (qb !== 8'h00) begin
                miscompares++;
                $display("FAIL clr_vs_we_reg%0d: got %h expected 00", i, qb);
            end
        end
        vectors++;
        if (wmask !== 4'b0000 || cy !== 1'b0) begin
            miscompares++; $display("FAIL clr_vs_we_flags: got wmask=%b cy=%b expected 0000/0", wmask, cy);
        end
        oe_ = 1'b1; ra = 2'd1; rb = 2'd1;
        we = 1'b1; op = OP_LOAD; waddr = 2'd1; wdata = 8'h77;
        #1;
        vectors++;
        if (bus !== KEEP) begin miscompares++; $display("FAIL oe_off_bus: got %h expected released (%h)", bus, KEEP); end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (qb !== 8'h77) begin miscompares++; $display("FAIL oe_off_write: got %h expected 77", qb); end
        vectors++;
        if (wmask !== 4'b0010) begin miscompares++; $display("FAIL oe_off_wmask: got %b expected 0010", wmask); end
    endtask

    task automatic test_oe_toggle();
        logic [7:0] exp_bus;
        do_op(2'd2, OP_LOAD, 8'hA5, 1'b0);
        ra = 2'd2; rb = 2'd2;
        for (int i = 0; i < 6; i++) begin
            oe_ = i[0];
            exp_bus = i[0] ? KEEP : 8'hA5;
            tick();
            vectors++;
            if (bus !== exp_bus) begin
                miscompares++; $display("FAIL toggle_bus%0d: got %h expected %h", i, bus, exp_bus);
            end
            vectors++;
            if (qb !== 8'hA5) begin
                miscompares++; $display("FAIL toggle_qb%0d: got %h expected a5", i, qb);
            end
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; op = OP_LOAD; waddr = 2'd0; wdata = 8'h00;
        sin = 1'b0; ra = 2'd0; rb = 2'd0; oe_ = 1'b1;
        tick();
        clr = 1'b0;
        test_reset();
        test_load_readback();
        test_inc_wrap();
        test_shift();
        test_simultaneous();
        test_oe_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_reg_bank_tri
